// File: rtl/exe_branch_redirect.sv
// exe_branch_redirect: resolves the branch held in EXE and issues a registered
// one-cycle redirect (Br_taken/Br_Addr) to the IF PC mux. The same redirect
// cycle drives the IF/ID and ID/EXE flush and kills the wrong-path instruction
// that occupies EXE while the redirect is in flight.
// Optional feature macro: BR_STATS_EN (adds resolved/taken branch counters).
module exe_branch_redirect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic [1:0]  Br_type,
  input  logic [31:0] Val1,
  input  logic [31:0] Reg2,
  input  logic [31:0] Val2,
  input  logic [31:0] PC_in,
  output logic        Br_taken,
  output logic [31:0] Br_Addr,
  output logic        flush,
  output logic        exe_kill,
  output logic        redirect_busy
`ifdef BR_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_taken
`endif
);

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  state_t      state;
  logic        cond;
  logic [31:0] target;

  // The word offset only keeps 30 bits after the <<2; the top two bits drop out.
  logic        unused_val2_hi;
  assign unused_val2_hi = ^Val2[31:30];

  // Branch condition and target, purely from the ID/EXE register fields.
  always_comb begin
    cond = 1'b0;
    unique case (Br_type)
      BR_BEZ:  cond = (Val1 == 32'h0);
      BR_BNE:  cond = (Val1 != Reg2);
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    target = PC_in + {Val2[29:0], 2'b00};
  end

  // Redirect FSM. Outputs are registered alongside the state so they are a
  // clean Moore decode; branches seen while in REDIRECT are wrong-path and
  // never touch Br_Addr or extend the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      Br_taken      <= 1'b0;
      flush         <= 1'b0;
      exe_kill      <= 1'b0;
      redirect_busy <= 1'b0;
      Br_Addr       <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!freeze && cond) begin
            state         <= REDIRECT;
            Br_Addr       <= target;
            Br_taken      <= 1'b1;
            flush         <= 1'b1;
            exe_kill      <= 1'b1;
            redirect_busy <= 1'b1;
          end
        end
        REDIRECT: begin
          if (!freeze) begin
            state         <= IDLE;
            Br_taken      <= 1'b0;
            flush         <= 1'b0;
            exe_kill      <= 1'b0;
            redirect_busy <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          Br_taken      <= 1'b0;
          flush         <= 1'b0;
          exe_kill      <= 1'b0;
          redirect_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_STATS_EN
  logic resolve_slot;
  assign resolve_slot = (state == IDLE) && !freeze;

  // Branch statistics; clear wins over a same-cycle increment, both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved <= 32'h0;
      stat_taken    <= 32'h0;
    end else if (stat_clr) begin
      stat_resolved <= 32'h0;
      stat_taken    <= 32'h0;
    end else begin
      if (resolve_slot && (Br_type != BR_NONE)) stat_resolved <= stat_resolved + 32'd1;
      if (resolve_slot && cond)                 stat_taken    <= stat_taken + 32'd1;
    end
  end
`endif

endmodule
